norm_ctrl: RTL
==============

NORM_CTRL -- requirements
Module: norm_ctrl

Interface
REQ-001 Parameter: N, 32, mantissa width in bits (power of two, >= 8).
REQ-002 Parameter: EW, 8, exponent width in bits.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream offers operand.
REQ-006 Port: in_ready  output  1  block accepts operand; high only in IDLE.
REQ-007 Port: in_mant  input  N  unnormalized mantissa.
REQ-008 Port: in_exp  input  EW  unsigned biased exponent of operand.
REQ-009 Port: out_valid  output  1  normalized result available.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: out_mant  output  N  normalized mantissa.
REQ-012 Port: out_exp  output  EW  adjusted exponent.
REQ-013 Port: out_zero  output  1  operand mantissa was all zeros.
REQ-014 Port: out_uflow  output  1  required shift exceeded in_exp; result denormal.
REQ-015 Port: busy  output  1  state is not IDLE.

Function
REQ-016 States SHALL be IDLE, DETECT, SHIFT, HOLD; one state per cycle, encoding free.
REQ-017 in_ready SHALL equal (state == IDLE); busy SHALL equal its inverse.
REQ-018 IDLE: on in_valid && in_ready SHALL register in_mant/in_exp and go to DETECT; otherwise stay.
REQ-019 DETECT: SHALL find index idx of most significant 1 in registered mantissa (leading-one detect, combinational).
REQ-020 DETECT, mantissa zero: SHALL set out_mant=0, out_exp=0, out_zero=1, out_uflow=0, go to HOLD.
REQ-021 DETECT, nonzero: required shift s = N-1-idx; effective shift e = min(s, exp); out_uflow = (s > exp); remaining count <- e.
REQ-022 DETECT: if e == 0 SHALL load outputs (mant, exp) and go to HOLD; else go to SHIFT.
REQ-023 SHIFT: each cycle SHALL shift mantissa left by min(remaining, 8), zero-filled, and decrement remaining and exponent by the same amount.
REQ-024 SHIFT: when remaining reaches 0 SHALL load out_mant/out_exp and go to HOLD; SHIFT cycles = ceil(e/8), max 4 for N=32.
REQ-025 Exponent arithmetic SHALL be unsigned EW-bit and never wrap; out_exp = exp - e >= 0.
REQ-026 Latency: with acceptance edge E0, out_valid SHALL rise after edge E0+2+ceil(e/8).
REQ-027 HOLD: out_valid=1; out_mant/out_exp/out_zero/out_uflow SHALL be stable until handshake.
REQ-028 HOLD: on out_ready SHALL go to IDLE; out_valid low and in_ready high from the next cycle.
REQ-029 out_ready while not in HOLD SHALL be ignored; in_valid while not in IDLE SHALL be ignored (no capture, no error).
REQ-030 All outputs except in_ready/busy SHALL be registered; out_valid low in all states but HOLD.
REQ-031 out_zero/out_uflow SHALL be cleared on every new acceptance.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, out_valid/out_zero/out_uflow=0, out_mant=0, out_exp=0, internal registers 0.
REQ-033 Reset asserted in any state, including mid-SHIFT or HOLD, SHALL discard the operation with no partial result presented.
REQ-034 After rst_n deasserts, in_ready SHALL be 1 and first edge SHALL accept a pending in_valid.

Verification
REQ-035 in_mant=0x8000_0000, in_exp=10 -> out_valid after E0+2; out_mant=0x8000_0000, out_exp=10, zero=0, uflow=0.
REQ-036 in_mant=0x0000_0001, in_exp=100 -> 4 SHIFT cycles, out_valid after E0+6; out_mant=0x8000_0000, out_exp=69.
REQ-037 in_mant=0, in_exp=55 -> out_valid after E0+2; out_mant=0, out_exp=0, out_zero=1.
REQ-038 in_mant=0x0000_0100, in_exp=5 -> s=23, e=5; out_mant=0x0000_2000, out_exp=0, out_uflow=1.
REQ-039 Walking single one at each of 32 positions, in_exp=200 -> out_mant=0x8000_0000, out_exp=200-(31-pos), latency per REQ-026; out_ready held low 10 cycles keeps outputs stable and in_ready low.
REQ-040 rst_n pulsed low during SHIFT of in_mant=1 -> outputs 0 immediately; after release in_ready=1, no out_valid for aborted operand.

Source files
------------

// File: rtl/norm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : norm_ctrl_if
// Description : Operand/result handshake bundle for the normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
interface norm_ctrl_if #(
    parameter int N  = 32,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_mant;
    logic [EW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_uflow;
    logic          busy;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, busy
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/norm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : norm_ctrl
// Description : Leading-one normalizer, left shift up to 8 bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_ctrl #(
    parameter int N  = 32,
    parameter int EW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    norm_ctrl_if.slave bus
);
    localparam int LW = $clog2(N);
    localparam int CW = (EW > LW) ? EW : LW;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_DETECT = 2'd1;
    localparam logic [1:0] C_SHIFT  = 2'd2;
    localparam logic [1:0] C_HOLD   = 2'd3;

    localparam logic [LW:0] C_STEP = (LW+1)'(8);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  mant_q, mant_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [N-1:0]  out_mant_q, out_mant_d;
    logic [EW-1:0] out_exp_q, out_exp_d;
    logic          out_zero_q, out_zero_d;
    logic          out_uflow_q, out_uflow_d;
    logic          out_valid_q, out_valid_d;

    logic [LW-1:0] w_lod_idx;
    logic          w_lod_zero;
    logic [LW-1:0] w_req_shift;
    logic [LW-1:0] w_eff_shift;
    logic          w_uflow;
    logic [LW-1:0] w_step;
    logic [N-1:0]  w_shift_mant;
    logic [EW-1:0] w_shift_exp;
    logic [LW-1:0] w_rem_left;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        w_lod_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (mant_q[i]) begin
                w_lod_idx = LW'(i);
            end
        end
    end

    assign w_lod_zero   = (mant_q == '0);
    assign w_req_shift  = LW'(N - 1) - w_lod_idx;
    assign w_uflow      = CW'(w_req_shift) > CW'(exp_q);
    assign w_eff_shift  = w_uflow ? LW'(exp_q) : w_req_shift;

    assign w_step       = ({1'b0, rem_q} > C_STEP) ? LW'(C_STEP) : rem_q;
    assign w_shift_mant = mant_q << w_step;
    assign w_shift_exp  = exp_q - EW'(w_step);
    assign w_rem_left   = rem_q - w_step;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:   if (bus.in_valid) state_d = C_DETECT;
            C_DETECT: state_d = (w_lod_zero || (w_eff_shift == '0)) ? C_HOLD : C_SHIFT;
            C_SHIFT:  if (w_rem_left == '0) state_d = C_HOLD;
            C_HOLD:   if (out_valid_q && bus.out_ready) state_d = C_IDLE;
            default:  state_d = C_IDLE;
        endcase
    end

    // Output / datapath next-values
    always_comb begin
        mant_d      = mant_q;
        exp_d       = exp_q;
        rem_d       = rem_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_zero_d  = out_zero_q;
        out_uflow_d = out_uflow_q;
        out_valid_d = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (bus.in_valid) begin
                    mant_d      = bus.in_mant;
                    exp_d       = bus.in_exp;
                    out_zero_d  = 1'b0;
                    out_uflow_d = 1'b0;
                end
            end
            C_DETECT: begin
                if (w_lod_zero) begin
                    out_mant_d  = '0;
                    out_exp_d   = '0;
                    out_zero_d  = 1'b1;
                    out_uflow_d = 1'b0;
                end else begin
                    out_uflow_d = w_uflow;
                    rem_d       = w_eff_shift;
                    if (w_eff_shift == '0) begin
                        out_mant_d = mant_q;
                        out_exp_d  = exp_q;
                    end
                end
            end
            C_SHIFT: begin
                mant_d = w_shift_mant;
                exp_d  = w_shift_exp;
                rem_d  = w_rem_left;
                if (w_rem_left == '0) begin
                    out_mant_d = w_shift_mant;
                    out_exp_d  = w_shift_exp;
                end
            end
            C_HOLD: begin
                // Result is offered one cycle after HOLD entry and withdrawn on the handshake edge.
                out_valid_d = !(out_valid_q && bus.out_ready);
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q      <= '0;
            exp_q       <= '0;
            rem_q       <= '0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            rem_q       <= rem_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_zero_q  <= out_zero_d;
            out_uflow_q <= out_uflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == C_IDLE);
    assign bus.busy      = (state_q != C_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_uflow = out_uflow_q;

endmodule
`default_nettype wire
